afu_data_buffer: RTL and testbench
==================================

// Module: afu_data_buffer
// PURPOSE
// - AFU-side terminator of the PSL buffer interface; serves the end opposite the PSL/host-side model.
// - Buffer-write sink: captures ha_bw* half-lines (host read data) into rx store; pulses when a tag's line is complete.
// - Buffer-read responder: returns tx-store data on ah_brdata/ah_brpar exactly BRLAT cycles after ha_brvalid.
// - AFU core fills tx store / drains rx store through local ports.
// PARAMETERS
// - TAG_W  5  tag index bits used; entries = 2**TAG_W lines of 128B (two 512b halves)
// - BRLAT  1  buffer-read latency driven on ah_brlat; legal values 1 or 3 only
// PORTS
// - ha_pclock      in   1    sole clock
// - reset          in   1    synchronous, active-high
// - ha_bwvalid     in   1    buffer write strobe
// - ha_bwtag       in   8    write tag
// - ha_bwtagpar    in   1    odd parity of ha_bwtag
// - ha_bwad        in   6    half select = bit 5; bits 0:4 must be 0
// - ha_bwdata      in   512  write half-line
// - ha_bwpar       in   8    odd parity, bit i covers dword i (data[64i +: 64])
// - ha_brvalid     in   1    buffer read strobe
// - ha_brtag       in   8    read tag
// - ha_brtagpar    in   1    odd parity of ha_brtag
// - ha_brad        in   6    half select = bit 5
// - ah_brlat       out  4    constant BRLAT
// - ah_brdata      out  512  read half-line
// - ah_brpar       out  8    odd parity per dword of ah_brdata
// - lw_valid/lw_tag[TAG_W]/lw_half/lw_data[512]  in   local write into tx store
// - lr_valid/lr_tag[TAG_W]/lr_half               in   local read of rx store
// - lr_rdata       out  512  rx data, valid 1 cycle after lr_valid
// - rx_clr_valid/rx_clr_tag[TAG_W]               in   clear half-seen state of a tag (on command issue)
// - rx_line_done   out  1    1-cycle pulse: both halves of rx_line_tag received
// - rx_line_tag    out  TAG_W
// - buf_err        out  1    sticky error (see CONFIGURATION)
// BEHAVIOUR
// - Reset: ah_brdata=0, ah_brpar=8'hFF, lr_rdata=0, rx_line_done=0, rx_line_tag=0, buf_err=0, half-seen bitmap cleared; RAM contents not reset.
// - ah_brlat = BRLAT always, reset included.
// - Index = tag[8-TAG_W:7] (low TAG_W bits); high tag bits ignored unless PARITY_CHECK_EN.
// - bw: on ha_bwvalid write ha_bwdata to rx[tag][half]; set seen[tag][half].
// - Line done: cycle after a bw write leaves seen[tag]==2'b11 -> rx_line_done=1, tag output, seen[tag] cleared.
// - Same-half rewrite before completion: data overwritten, no extra pulse.
// - rx_clr + bw same tag same cycle: clear first, then bw sets its bit.
// - br: cycle N ha_brvalid -> ah_brdata/ah_brpar valid at N+BRLAT; pipeline of 1 RAM read + BRLAT-1 regs.
// - Back-to-back br every cycle supported; between valid returns ah_brdata holds last value.
// - ah_brpar generated from data: par[i] = ~^data[64i +: 64].
// - Collisions: local write vs br, or bw vs local read, same index/half same cycle -> read returns OLD data.
// - Reset mid-operation: in-flight br returns dropped, bitmap cleared; pipeline valids cleared.
// CONFIGURATION
// - PARITY_CHECK_EN defined: check ha_bwtagpar, ha_bwpar, ha_brtagpar, ha_bwad[0:4]==0, tag high bits==0;
//   any failure sets buf_err (sticky until reset); a failing bw is still written.
// - PARITY_CHECK_EN undefined: no checking; buf_err tied 0.
// STRUCTURE
// - Package afu_buf_pkg: HALF_W=512, DW_PER_HALF=8, BRLAT legal-value constants, odd-parity function over a half-line.
// - Sub-module afu_buf_ram: 1W/1R synchronous RAM, read-before-write, 2**(TAG_W+1) x 512; instantiated twice (rx, tx).
// TESTING
// - bw tag 3 half 0 then half 1 (bwad=6'h01) -> rx_line_done pulse 1 cycle after 2nd write, rx_line_tag=3.
// - lw tag 5 half 1 = {8{64'h0123_4567_89AB_CDEF}}; br tag 5 ad 6'h01 at N -> data at N+BRLAT, par 8'hFF (odd-parity rule).
// - BRLAT=3: br every cycle for tags 0..7 -> returns in order at N+3..N+10, no gaps.
// - bw tag 2 half 0 with rx_clr tag 2 same cycle, then half 1 -> line done fires; clr alone after half 0 -> no pulse.
// - lw and br same tag/half same cycle -> br returns old data; lr vs bw collision likewise.
// - PARITY_CHECK_EN: ha_bwtagpar wrong -> buf_err=1 next cycle, stays 1 until reset; without macro stays 0.

Source files
------------

// File: rtl/afu_buf_pkg.sv
// afu_buf_pkg: shared constants and helpers for the AFU-side PSL data buffer.
//   HALF_W       width of one half-line (512b, half of a 128B line)
//   DW_PER_HALF  number of 64b dwords per half-line (one parity bit each)
//   BRLAT_SHORT / BRLAT_LONG  the only buffer-read latencies the PSL accepts
//   odd_par_half()  per-dword odd parity of a half-line
package afu_buf_pkg;

  localparam int HALF_W      = 512;
  localparam int DW_W        = 64;
  localparam int DW_PER_HALF = HALF_W / DW_W;
  localparam int BRLAT_SHORT = 1;
  localparam int BRLAT_LONG  = 3;

  // Odd parity: each bit is set when its dword holds an even number of ones.
  function automatic logic [DW_PER_HALF-1:0] odd_par_half(input logic [HALF_W-1:0] data);
    logic [DW_PER_HALF-1:0] par;
    par = {DW_PER_HALF{1'b0}};
    for (int i = 0; i < DW_PER_HALF; i++) begin
      par[i] = ~^data[DW_W*i +: DW_W];
    end
    return par;
  endfunction

endpackage

// File: rtl/afu_buf_ram.sv
// afu_buf_ram: one-write / one-read synchronous half-line RAM.
// A read and a write to the same address in the same cycle return the old
// contents. The read register resets to zero and holds its value while no
// read is requested; the storage array itself is never reset.
//   clk, reset      clock and synchronous active-high reset
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata valid the cycle after re
//   rdata           registered read data
module afu_buf_ram
  import afu_buf_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [HALF_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [HALF_W-1:0] rdata
);

  logic [HALF_W-1:0] mem [0:(2**AW)-1];
  logic [HALF_W-1:0] rdata_q;
  logic [HALF_W-1:0] rdata_d;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data sampled from the array before this cycle's write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {HALF_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/afu_data_buffer.sv
// afu_data_buffer: AFU-side terminator of the PSL buffer interface.
//   ha_pclock, reset                       clock, synchronous active-high reset
//   ha_bw*                                 buffer write (host read data) into rx store
//   ha_br*  -> ah_brdata/ah_brpar          buffer read from tx store, BRLAT cycles later
//   ah_brlat                               constant read latency advertised to the PSL
//   lw_*                                   AFU core writes tx store
//   lr_* -> lr_rdata                       AFU core reads rx store, one cycle later
//   rx_clr_*                               forget half-seen state of a tag at command issue
//   rx_line_done/rx_line_tag               one-cycle pulse when both halves of a line arrived
//   buf_err                                sticky interface error
// Optional feature macro PARITY_CHECK_EN: checks tag parity, data parity,
// ha_bwad low bits and unused tag bits; without it buf_err is tied low.
// Tag/address bit numbering: PSL bit 0 is the MSB, so the tag index (PSL
// bits 8-TAG_W..7) is ha_*tag[TAG_W-1:0] and the half select (PSL bit 5)
// is ha_*ad[0].
module afu_data_buffer
  import afu_buf_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int BRLAT = 1
) (
  input  logic                   ha_pclock,
  input  logic                   reset,
  input  logic                   ha_bwvalid,
  input  logic [7:0]             ha_bwtag,
  input  logic                   ha_bwtagpar,
  input  logic [5:0]             ha_bwad,
  input  logic [HALF_W-1:0]      ha_bwdata,
  input  logic [DW_PER_HALF-1:0] ha_bwpar,
  input  logic                   ha_brvalid,
  input  logic [7:0]             ha_brtag,
  input  logic                   ha_brtagpar,
  input  logic [5:0]             ha_brad,
  output logic [3:0]             ah_brlat,
  output logic [HALF_W-1:0]      ah_brdata,
  output logic [DW_PER_HALF-1:0] ah_brpar,
  input  logic                   lw_valid,
  input  logic [TAG_W-1:0]       lw_tag,
  input  logic                   lw_half,
  input  logic [HALF_W-1:0]      lw_data,
  input  logic                   lr_valid,
  input  logic [TAG_W-1:0]       lr_tag,
  input  logic                   lr_half,
  output logic [HALF_W-1:0]      lr_rdata,
  input  logic                   rx_clr_valid,
  input  logic [TAG_W-1:0]       rx_clr_tag,
  output logic                   rx_line_done,
  output logic [TAG_W-1:0]       rx_line_tag,
  output logic                   buf_err
);

  localparam int ENTRIES = 2**TAG_W;

  logic [TAG_W-1:0]              bw_idx_s;
  logic [TAG_W-1:0]              br_idx_s;
  logic                          bw_half_s;
  logic [HALF_W-1:0]             tx_rdata_s;
  logic [HALF_W-1:0]             brdata_s;
  logic [ENTRIES-1:0][1:0]       seen_q;
  logic [ENTRIES-1:0][1:0]       seen_d;
  logic                          line_done_q;
  logic                          line_done_d;
  logic [TAG_W-1:0]              line_tag_q;
  logic [TAG_W-1:0]              line_tag_d;

  assign bw_idx_s  = ha_bwtag[TAG_W-1:0];
  assign br_idx_s  = ha_brtag[TAG_W-1:0];
  assign bw_half_s = ha_bwad[0];

  // Illegal BRLAT values fall back to the short pipeline, and the advertised
  // latency follows the pipeline actually built.
  assign ah_brlat = (BRLAT == BRLAT_LONG) ? 4'(BRLAT_LONG) : 4'(BRLAT_SHORT);

  afu_buf_ram #(.AW(TAG_W + 1)) u_rx_ram (
    .clk   (ha_pclock),
    .reset (reset),
    .we    (ha_bwvalid),
    .waddr ({bw_idx_s, bw_half_s}),
    .wdata (ha_bwdata),
    .re    (lr_valid),
    .raddr ({lr_tag, lr_half}),
    .rdata (lr_rdata)
  );

  afu_buf_ram #(.AW(TAG_W + 1)) u_tx_ram (
    .clk   (ha_pclock),
    .reset (reset),
    .we    (lw_valid),
    .waddr ({lw_tag, lw_half}),
    .wdata (lw_data),
    .re    (ha_brvalid),
    .raddr ({br_idx_s, ha_brad[0]}),
    .rdata (tx_rdata_s)
  );

  generate
    if (BRLAT == BRLAT_LONG) begin : g_brlat_long
      // The RAM read register is the first stage; two more stages follow.
      logic [1:0]        brv_q;
      logic [1:0]        brv_d;
      logic [HALF_W-1:0] st2_q;
      logic [HALF_W-1:0] st2_d;
      logic [HALF_W-1:0] out_q;
      logic [HALF_W-1:0] out_d;

      // Stage advance; each stage only loads when a read is in it so the
      // output holds its last returned value between reads.
      always_comb begin
        brv_d = {brv_q[0], ha_brvalid};
        st2_d = st2_q;
        out_d = out_q;
        if (brv_q[0]) begin
          st2_d = tx_rdata_s;
        end else begin
          st2_d = st2_q;
        end
        if (brv_q[1]) begin
          out_d = st2_q;
        end else begin
          out_d = out_q;
        end
      end

      // Read-return pipeline registers; reset drops reads in flight.
      always_ff @(posedge ha_pclock) begin
        if (reset) begin
          brv_q <= 2'b00;
          st2_q <= {HALF_W{1'b0}};
          out_q <= {HALF_W{1'b0}};
        end else begin
          brv_q <= brv_d;
          st2_q <= st2_d;
          out_q <= out_d;
        end
      end

      assign brdata_s = out_q;
    end else begin : g_brlat_short
      // The RAM read register already holds its value between reads.
      assign brdata_s = tx_rdata_s;
    end
  endgenerate

  // Parity is derived from the output register so data and parity always agree.
  assign ah_brdata = brdata_s;
  assign ah_brpar  = odd_par_half(brdata_s);

  // Half-seen bookkeeping: a clear lands before a same-cycle write sets its bit.
  always_comb begin
    seen_d      = seen_q;
    line_done_d = 1'b0;
    line_tag_d  = line_tag_q;
    if (rx_clr_valid) begin
      seen_d[rx_clr_tag] = 2'b00;
    end else begin
      seen_d[rx_clr_tag] = seen_q[rx_clr_tag];
    end
    if (ha_bwvalid) begin
      seen_d[bw_idx_s][bw_half_s] = 1'b1;
      if (seen_d[bw_idx_s] == 2'b11) begin
        line_done_d      = 1'b1;
        line_tag_d       = bw_idx_s;
        seen_d[bw_idx_s] = 2'b00;
      end else begin
        line_done_d = 1'b0;
      end
    end else begin
      line_done_d = 1'b0;
    end
  end

  // Line-completion state registers.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      seen_q      <= {ENTRIES{2'b00}};
      line_done_q <= 1'b0;
      line_tag_q  <= {TAG_W{1'b0}};
    end else begin
      seen_q      <= seen_d;
      line_done_q <= line_done_d;
      line_tag_q  <= line_tag_d;
    end
  end

  assign rx_line_done = line_done_q;
  assign rx_line_tag  = line_tag_q;

`ifdef PARITY_CHECK_EN
  logic err_q;
  logic err_d;
  logic bw_bad_s;
  logic br_bad_s;
  logic unused_s;

  // Interface checks; a failing write is still stored, only the flag is raised.
  always_comb begin
    bw_bad_s = 1'b0;
    br_bad_s = 1'b0;
    if (ha_bwvalid) begin
      bw_bad_s = (^{ha_bwtag, ha_bwtagpar} == 1'b0) ||
                 (ha_bwpar != odd_par_half(ha_bwdata)) ||
                 (ha_bwad[5:1] != 5'b00000) ||
                 (ha_bwtag[7:TAG_W] != {(8-TAG_W){1'b0}});
    end else begin
      bw_bad_s = 1'b0;
    end
    if (ha_brvalid) begin
      br_bad_s = (^{ha_brtag, ha_brtagpar} == 1'b0) ||
                 (ha_brtag[7:TAG_W] != {(8-TAG_W){1'b0}});
    end else begin
      br_bad_s = 1'b0;
    end
    err_d = err_q | bw_bad_s | br_bad_s;
  end

  // Sticky error flag.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign buf_err  = err_q;
  assign unused_s = ^ha_brad[5:1];
`else
  logic unused_s;

  assign buf_err  = 1'b0;
  assign unused_s = ^{ha_brad[5:1], ha_bwad[5:1], ha_bwtagpar, ha_bwpar, ha_brtagpar,
                      ha_bwtag[7:TAG_W], ha_brtag[7:TAG_W]};
`endif

endmodule

// File: tb/tb_afu_data_buffer.sv
// Self-checking bench for afu_data_buffer. Two instances share one stimulus
// stream: one with BRLAT=1, one with BRLAT=3. A behavioural model (arrays of
// line contents, a set of half-seen flags, and queues of timed read returns)
// predicts every output after every clock edge.
module tb_afu_data_buffer;

  localparam int TAG_W   = 5;
  localparam int ENTRIES = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ha_bwvalid, ha_bwtagpar, ha_brvalid, ha_brtagpar;
  logic [7:0]   ha_bwtag, ha_brtag, ha_bwpar;
  logic [5:0]   ha_bwad, ha_brad;
  logic [511:0] ha_bwdata, lw_data;
  logic         lw_valid, lw_half, lr_valid, lr_half, rx_clr_valid;
  logic [4:0]   lw_tag, lr_tag, rx_clr_tag;

  logic [3:0]   brlat1, brlat3;
  logic [511:0] brdata1, brdata3, lrd1, lrd3;
  logic [7:0]   brpar1, brpar3;
  logic         done1, done3, err1, err3;
  logic [4:0]   ltag1, ltag3;

  always #5 clk = ~clk;

  afu_data_buffer #(.TAG_W(TAG_W), .BRLAT(1)) u_dut1 (
    .ha_pclock(clk), .reset(reset),
    .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar), .ha_bwad(ha_bwad),
    .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
    .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brtagpar(ha_brtagpar), .ha_brad(ha_brad),
    .ah_brlat(brlat1), .ah_brdata(brdata1), .ah_brpar(brpar1),
    .lw_valid(lw_valid), .lw_tag(lw_tag), .lw_half(lw_half), .lw_data(lw_data),
    .lr_valid(lr_valid), .lr_tag(lr_tag), .lr_half(lr_half), .lr_rdata(lrd1),
    .rx_clr_valid(rx_clr_valid), .rx_clr_tag(rx_clr_tag),
    .rx_line_done(done1), .rx_line_tag(ltag1), .buf_err(err1)
  );

  afu_data_buffer #(.TAG_W(TAG_W), .BRLAT(3)) u_dut3 (
    .ha_pclock(clk), .reset(reset),
    .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar), .ha_bwad(ha_bwad),
    .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
    .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brtagpar(ha_brtagpar), .ha_brad(ha_brad),
    .ah_brlat(brlat3), .ah_brdata(brdata3), .ah_brpar(brpar3),
    .lw_valid(lw_valid), .lw_tag(lw_tag), .lw_half(lw_half), .lw_data(lw_data),
    .lr_valid(lr_valid), .lr_tag(lr_tag), .lr_half(lr_half), .lr_rdata(lrd3),
    .rx_clr_valid(rx_clr_valid), .rx_clr_tag(rx_clr_tag),
    .rx_line_done(done3), .rx_line_tag(ltag3), .buf_err(err3)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; logic [511:0] data; } ret_t;

  logic [511:0] m_rx [ENTRIES][2];
  logic [511:0] m_tx [ENTRIES][2];
  bit           m_seen [ENTRIES][2];
  logic [511:0] m_lr, m_br1, m_br3;
  bit           m_done, m_err;
  int           m_tag;
  ret_t         q1[$], q3[$];
  int           cyc;
  int           n_pass, n_total;

  function automatic logic [7:0] par_of(input logic [511:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ($countones(d[64*i +: 64]) % 2 == 0);
    return p;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Predicts the state after the coming clock edge from the inputs now applied.
  task automatic model_edge();
    int bwi, bwh, bri, brh;
    cyc++;
    if (reset) begin
      foreach (m_seen[i, j]) m_seen[i][j] = 1'b0;
      m_lr = '0; m_br1 = '0; m_br3 = '0;
      m_done = 1'b0; m_tag = 0; m_err = 1'b0;
      q1.delete(); q3.delete();
      return;
    end
    bwi = int'(ha_bwtag) % ENTRIES; bwh = int'(ha_bwad[0]);
    bri = int'(ha_brtag) % ENTRIES; brh = int'(ha_brad[0]);
    // reads see the contents from before this cycle's writes
    if (lr_valid) m_lr = m_rx[lr_tag][lr_half];
    if (ha_brvalid) begin
      q1.push_back('{due: cyc,     data: m_tx[bri][brh]});
      q3.push_back('{due: cyc + 2, data: m_tx[bri][brh]});
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin m_br1 = q1[0].data; void'(q1.pop_front()); end
    while (q3.size() > 0 && q3[0].due <= cyc) begin m_br3 = q3[0].data; void'(q3.pop_front()); end
`ifdef PARITY_CHECK_EN
    if (ha_bwvalid) begin
      if ($countones({ha_bwtag, ha_bwtagpar}) % 2 == 0) m_err = 1'b1;
      if ((ha_bwad >> 1) != 0) m_err = 1'b1;
      if (int'(ha_bwtag) >= ENTRIES) m_err = 1'b1;
      for (int i = 0; i < 8; i++)
        if (ha_bwpar[i] != ($countones(ha_bwdata[64*i +: 64]) % 2 == 0)) m_err = 1'b1;
    end
    if (ha_brvalid) begin
      if ($countones({ha_brtag, ha_brtagpar}) % 2 == 0) m_err = 1'b1;
      if (int'(ha_brtag) >= ENTRIES) m_err = 1'b1;
    end
`endif
    if (lw_valid) m_tx[lw_tag][lw_half] = lw_data;
    if (ha_bwvalid) m_rx[bwi][bwh] = ha_bwdata;
    if (rx_clr_valid) begin m_seen[rx_clr_tag][0] = 1'b0; m_seen[rx_clr_tag][1] = 1'b0; end
    m_done = 1'b0;
    if (ha_bwvalid) begin
      m_seen[bwi][bwh] = 1'b1;
      if (m_seen[bwi][0] && m_seen[bwi][1]) begin
        m_done = 1'b1; m_tag = bwi;
        m_seen[bwi][0] = 1'b0; m_seen[bwi][1] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("brlat1", brlat1, 4'd1);          chk("brlat3", brlat3, 4'd3);
    chk("brdata1", brdata1, m_br1);       chk("brpar1", brpar1, par_of(m_br1));
    chk("brdata3", brdata3, m_br3);       chk("brpar3", brpar3, par_of(m_br3));
    chk("lr_rdata1", lrd1, m_lr);         chk("lr_rdata3", lrd3, m_lr);
    chk("line_done1", done1, m_done);     chk("line_done3", done3, m_done);
    chk("line_tag1", ltag1, m_tag);       chk("line_tag3", ltag3, m_tag);
    chk("buf_err1", err1, m_err);         chk("buf_err3", err3, m_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    compare_all();
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    ha_bwvalid = 1'b0; ha_brvalid = 1'b0; lw_valid = 1'b0; lr_valid = 1'b0; rx_clr_valid = 1'b0;
  endtask

  task automatic set_bw(input int tag, input bit half, input logic [511:0] d);
    ha_bwvalid = 1'b1; ha_bwtag = 8'(tag); ha_bwtagpar = ($countones(8'(tag)) % 2 == 0);
    ha_bwad = {5'b00000, half}; ha_bwdata = d; ha_bwpar = par_of(d);
  endtask

  task automatic set_br(input int tag, input bit half);
    ha_brvalid = 1'b1; ha_brtag = 8'(tag); ha_brtagpar = ($countones(8'(tag)) % 2 == 0);
    ha_brad = {5'b00000, half};
  endtask

  task automatic set_lw(input int tag, input bit half, input logic [511:0] d);
    lw_valid = 1'b1; lw_tag = 5'(tag); lw_half = half; lw_data = d;
  endtask

  typedef struct {
    bit bw_v; int tag; bit half; bit clr_v; int clr_tag; bit exp_done; int exp_tag;
  } vec_t;
  vec_t tbl[15];

  logic [511:0] pat, old_d, new_d;
  logic [511:0] seq_d [8];
  bit           exp_err;

  initial begin
    tbl[0]  = '{1, 3, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 1, 0, 0, 1, 3};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 3};
    tbl[3]  = '{1, 2, 0, 1, 2, 0, 3};   // clear and write same tag: bit survives
    tbl[4]  = '{1, 2, 1, 0, 0, 1, 2};
    tbl[5]  = '{1, 7, 0, 0, 0, 0, 2};
    tbl[6]  = '{0, 0, 0, 1, 7, 0, 2};   // clear alone forgets half 0
    tbl[7]  = '{1, 7, 1, 0, 0, 0, 2};
    tbl[8]  = '{1, 7, 1, 0, 0, 0, 2};   // same-half rewrite
    tbl[9]  = '{1, 7, 0, 0, 0, 1, 7};
    tbl[10] = '{1, 9, 1, 0, 0, 0, 7};
    tbl[11] = '{1, 9, 1, 0, 0, 0, 7};
    tbl[12] = '{1, 9, 0, 0, 0, 1, 9};
    tbl[13] = '{1, 4, 0, 1, 9, 0, 9};   // clear of another tag does not disturb
    tbl[14] = '{1, 4, 1, 0, 0, 1, 4};

    n_pass = 0; n_total = 0; cyc = 0;
    ha_bwtag = 8'h00; ha_bwtagpar = 1'b1; ha_bwad = 6'h00; ha_bwdata = '0; ha_bwpar = 8'hFF;
    ha_brtag = 8'h00; ha_brtagpar = 1'b1; ha_brad = 6'h00;
    lw_tag = 5'd0; lw_half = 1'b0; lw_data = '0; lr_tag = 5'd0; lr_half = 1'b0; rx_clr_tag = 5'd0;
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // fill both stores so every later read has defined contents
    for (int t = 0; t < ENTRIES; t++)
      for (int h = 0; h < 2; h++) begin
        idle(); set_bw(t, h[0], rand512()); set_lw(t, h[0], rand512()); step();
      end
    idle();
    reset = 1'b1; step(); reset = 1'b0;

    // line completion table
    for (int i = 0; i < 15; i++) begin
      idle();
      if (tbl[i].bw_v) set_bw(tbl[i].tag, tbl[i].half, rand512());
      if (tbl[i].clr_v) begin rx_clr_valid = 1'b1; rx_clr_tag = 5'(tbl[i].clr_tag); end
      step();
      chk($sformatf("tbl%0d_done", i), done1, tbl[i].exp_done);
      chk($sformatf("tbl%0d_tag", i), ltag1, tbl[i].exp_tag);
    end

    // known pattern, latency and parity
    pat = {8{64'h0123_4567_89AB_CDEF}};
    idle(); set_lw(5, 1'b1, pat); step();
    idle(); set_br(5, 1'b1); step();
    chk("pat_brdata1", brdata1, pat); chk("pat_brpar1", brpar1, 8'hFF);
    idle(); step();
    chk("pat_brdata3_early", (brdata3 === pat), 1'b0);
    step();
    chk("pat_brdata3", brdata3, pat); chk("pat_brpar3", brpar3, 8'hFF);

    // back-to-back reads, returns in order with no gaps
    for (int t = 0; t < 8; t++) begin seq_d[t] = rand512(); idle(); set_lw(t, 1'b0, seq_d[t]); step(); end
    for (int i = 0; i < 11; i++) begin
      idle();
      if (i < 8) set_br(i, 1'b0);
      step();
      if (i < 8) chk($sformatf("b2b1_%0d", i), brdata1, seq_d[i]);
      if (i >= 2 && i < 10) chk($sformatf("b2b3_%0d", i - 2), brdata3, seq_d[i - 2]);
    end

    // local write vs buffer read collision
    old_d = rand512(); new_d = rand512();
    idle(); set_lw(6, 1'b0, old_d); step();
    idle(); set_lw(6, 1'b0, new_d); set_br(6, 1'b0); step();
    chk("lw_br_old", brdata1, old_d);
    idle(); set_br(6, 1'b0); step();
    chk("lw_br_new", brdata1, new_d);

    // buffer write vs local read collision
    idle(); set_bw(11, 1'b1, old_d); step();
    idle(); set_bw(11, 1'b1, new_d); lr_valid = 1'b1; lr_tag = 5'd11; lr_half = 1'b1; step();
    chk("bw_lr_old", lrd1, old_d);
    idle(); lr_valid = 1'b1; lr_tag = 5'd11; lr_half = 1'b1; step();
    chk("bw_lr_new", lrd1, new_d);

    // reset while a long-latency read is in flight: its return is dropped
    idle(); set_br(7, 1'b0); step();
    idle(); reset = 1'b1; step(); reset = 1'b0;
    idle(); step(); step();
    chk("rst_drop3", brdata3, 512'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      if (!reset) begin
        if ($urandom_range(0, 1) == 1) set_bw($urandom_range(0, ENTRIES - 1), 1'($urandom), rand512());
        if ($urandom_range(0, 1) == 1) set_br($urandom_range(0, ENTRIES - 1), 1'($urandom));
        if ($urandom_range(0, 2) == 0) set_lw($urandom_range(0, ENTRIES - 1), 1'($urandom), rand512());
        if ($urandom_range(0, 2) == 0) begin
          lr_valid = 1'b1; lr_tag = 5'($urandom); lr_half = 1'($urandom);
        end
        if ($urandom_range(0, 7) == 0) begin rx_clr_valid = 1'b1; rx_clr_tag = 5'($urandom); end
      end
      step();
    end
    reset = 1'b0;

    // bad write-tag parity
`ifdef PARITY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    idle(); set_bw(1, 1'b0, rand512()); ha_bwtagpar = ~ha_bwtagpar; step();
    chk("err_set", err1, exp_err);
    idle(); step(); step();
    chk("err_sticky", err1, exp_err);
    reset = 1'b1; step(); reset = 1'b0;
    chk("err_reset", err1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
